demux_1_8_hold: RTL
===================

// Module: demux_1_8_hold
// PURPOSE
//  - Inverse of the 8:1 selector in the g04_alu group: routes one input stream to one of 8 output channels.
//  - Each channel has a one-entry holding register with a valid/ready handshake.
//  - Sits between a single producer (ALU result path) and up to 8 consumers (LEDs, UART, regs).
//  - A channel keeps its word until the consumer accepts it.
// PARAMETERS
//  - W         8  data width of input word and of each output channel
//  - NUM_CH    8  channel count; fixed at 8; SEL_W = 3
// PORTS
//  - clk        in   1      single clock, all logic on rising edge
//  - rst_n      in   1      synchronous reset, active-low
//  - in_data    in   W      word to route
//  - in_sel     in   3      target channel (ignored when AUTO_SEL_EN is defined)
//  - in_valid   in   1      producer offers in_data
//  - in_ready   out  1      block accepts the word this cycle
//  - out_data   out  8*W    channel k occupies bits [k*W +: W]
//  - out_valid  out  8      channel k holds an unconsumed word
//  - out_ready  in   8      consumer k accepts its word this cycle
//  - cur_sel    out  3      channel that the next accepted word goes to
//  - xfer_cnt   out  8      count of accepted input words, wraps 255->0
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - out_valid=0, out_data=0, cur_sel=0, xfer_cnt=0.
//    - Any held words are discarded, including during a transfer.
//    - Registered outputs take their reset values the cycle after the edge.
//    - in_ready is combinational and is driven 0 while rst_n=0.
//  - Target channel t: in_sel when AUTO_SEL_EN is undefined, otherwise the internal pointer.
//  - cur_sel shows t.
//  - in_ready = ~out_valid[t] | out_ready[t].
//    - Accepting into a channel that is being drained in the same cycle is allowed: full throughput per channel.
//  - Accept: in_valid & in_ready. On that edge:
//    - out_data[t] <= in_data, out_valid[t] <= 1, xfer_cnt++.
//  - Drain of channel k: out_valid[k] & out_ready[k], and no accept into k.
//    - out_valid[k] <= 0; out_data[k] is kept (not cleared).
//  - Channels drain independently; several may drain in the same cycle.
//  - Latency: one cycle from accept to out_valid.
//  - No combinational path from in_data to out_data.
//  - Non-target channels are unaffected by an accept.
//  - Producer rules:
//    - in_data and in_sel must stay stable while in_valid=1 & in_ready=0.
//    - The block does not flag violations.
//  - No word is ever dropped or duplicated. A full, undrained target channel stalls the input (in_ready=0).
// CONFIGURATION
//  - Macro DEMUX_AUTO_SEL_EN.
//  - Defined:
//    - in_sel is ignored.
//    - A 3-bit round-robin pointer starts at 0 and advances by 1 (7->0) on each accept.
//    - A stalled target holds the pointer; no channel is skipped.
//  - Undefined: routing follows in_sel; cur_sel = in_sel.
// STRUCTURE
//  - Package demux_pkg:
//    - localparam NUM_CH=8, SEL_W=3.
//    - Function ch_slice(k) gives the base offset k*W.
//  - Sub-module demux_ch_reg (x8, generate loop):
//    - One-entry register per channel.
//    - Inputs: load, data_in, rdy. Outputs: data_q, vld.
//  - Top level holds the target decode, the in_ready mux, the pointer and xfer_cnt.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles mid-stream -> out_valid=8'h00, xfer_cnt=0, in_ready=0 during reset.
//  - Route: out_ready=8'hFF; send 0xA5 to sel=5 -> next cycle out_valid=8'h20, out_data[47:40]=0xA5, xfer_cnt=1.
//  - Stall: out_ready=0; send 0x11 to sel=2, then 0x22 to sel=2.
//    - in_ready=0 while 0x22 is offered; ch2 still holds 0x11.
//    - Raise out_ready[2]: 0x22 is accepted that same cycle.
//  - Throughput: out_ready[0]=1; 16 back-to-back words to sel=0.
//    - One accept per cycle; out_data[7:0] follows the input with 1-cycle lag; xfer_cnt=16.
//  - Independence: fill ch1 and ch6 with out_ready=0; drain only ch6.
//    - out_valid goes 8'h42 -> 8'h02; ch1 data is intact.
//  - Auto-select (DEMUX_AUTO_SEL_EN): out_ready=8'hFF, 9 words.
//    - Channels 0..7 then 0 are loaded.
//    - With out_ready[3]=0 and ch3 full, the pointer stalls at 3.
//  - Wrap: 256 accepts -> xfer_cnt=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1:8 holding demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int DEF_W  = 8;

  // Base bit offset of channel k inside the flattened out_data bus.
  function automatic int ch_slice(input int k, input int w = DEF_W);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// One-entry holding register for a single output channel with valid/ready drain.
module demux_ch_reg
  import demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         rdy,
  output logic [W-1:0] data_q,
  output logic         vld
);

  logic [W-1:0] data_d;
  logic         vld_q;
  logic         vld_d;

  // A load wins over a same-cycle drain so the channel keeps full throughput.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load) begin
      data_d = data_in;
      vld_d  = 1'b1;
    end else if (vld_q && rdy) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign vld = vld_q;

endmodule

// File: rtl/demux_1_8_hold.sv
// 1:8 demux with a one-entry hold register per channel and valid/ready handshakes.
// Define DEMUX_AUTO_SEL_EN to route by an internal round-robin pointer instead of in_sel.
module demux_1_8_hold
  import demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_CH*W-1:0] out_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [SEL_W-1:0]    cur_sel,
  output logic [7:0]          xfer_cnt
);

  logic [SEL_W-1:0]  tgt;
  logic              accept;
  logic [NUM_CH-1:0] load;
  logic [7:0]        xfer_cnt_q;
  logic [7:0]        xfer_cnt_d;

`ifdef DEMUX_AUTO_SEL_EN
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic             unused_sel;

  assign unused_sel = ^in_sel;
  assign tgt        = ptr_q;

  // Pointer only moves on an accept, so a stalled channel is never skipped.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign tgt = in_sel;
`endif

  assign cur_sel  = tgt;
  assign in_ready = rst_n & (~out_valid[tgt] | out_ready[tgt]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    load       = '0;
    xfer_cnt_d = xfer_cnt_q;
    if (accept) begin
      load[tgt]  = 1'b1;
      xfer_cnt_d = xfer_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int BASE = ch_slice(k, W);

    demux_ch_reg #(
      .W (W)
    ) u_ch_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[k]),
      .data_in (in_data),
      .rdy     (out_ready[k]),
      .data_q  (out_data[BASE +: W]),
      .vld     (out_valid[k])
    );
  end

endmodule
